axil_req_master: RTL and testbench

- Single-outstanding AXI4-Lite master that turns a simple request/response port into AXI4-Lite transactions.
- Sits directly upstream of mem_wrapper and drives its axi4_lite_if slave port. Register-access logic (host bridge, sequencers) issues one word access at a time through it.
- Includes a per-transaction watchdog so that a hung slave cannot stall the requester forever.

---
 rtl/axil_req_master_if.sv | 40 ++++
 rtl/axil_req_master.sv | 205 ++++++++++++++++++++
 tb/tb_axil_req_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_req_master_if.sv
// AXI4-Lite signal bundle (32-bit data) with master and slave views.
interface axi4_lite_if #(
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport m (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport s (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/axil_req_master.sv
// Single-outstanding AXI4-Lite master: one request in, one response out,
// with a per-transaction watchdog that aborts and drains a hung slave.
module axil_req_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    axi4_lite_if.m            axi
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DRAIN
    } state_t;

    state_t            state;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q, addr_al;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              drain_wr;
    logic [CW-1:0]     cnt;
    logic              accept, busy, expire, tmo_fire;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              aw_left, w_left, ar_left;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awprot  = '0;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arprot  = '0;
    assign axi.rready  = rready_q;

    // Handshake decode, word alignment and watchdog expiry.
    always_comb begin
        addr_al  = req_addr & ~ADDR_W'(3);
        accept   = (state == IDLE) && req_ready && req_valid;
        busy     = (state != IDLE) && (state != DRAIN);
        aw_hs    = awvalid_q && axi.awready;
        w_hs     = wvalid_q && axi.wready;
        b_hs     = bready_q && axi.bvalid;
        ar_hs    = arvalid_q && axi.arready;
        r_hs     = rready_q && axi.rvalid;
        aw_left  = awvalid_q && !axi.awready;
        w_left   = wvalid_q && !axi.wready;
        ar_left  = arvalid_q && !axi.arready;
        expire   = 1'b0;
        if (TIMEOUT != 0 && busy) begin
            expire = (int'(cnt) >= TIMEOUT - 1);
        end
        // A completing response in the expiry cycle takes precedence.
        tmo_fire = expire && !((state == WRESP) && b_hs) && !((state == RDATA) && r_hs);
    end

    // Watchdog counter; the accept cycle counts as the first elapsed cycle,
    // so expiry lands exactly TIMEOUT cycles after accept.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (TIMEOUT == 0) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(1);
        end else if (busy) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Transaction FSM with registered AXI and response outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            drain_wr    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (tmo_fire) begin
                rsp_valid   <= 1'b1;
                rsp_resp    <= 2'b11;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        drain_wr  <= req_write;
                        if (req_write) begin
                            awaddr_q  <= addr_al;
                            wdata_q   <= req_wdata;
                            wstrb_q   <= req_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WADDR_DATA;
                        end else begin
                            araddr_q  <= addr_al;
                            arvalid_q <= 1'b1;
                            state     <= RADDR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WADDR_DATA: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs) wvalid_q <= 1'b0;
                    if (tmo_fire) begin
                        state <= DRAIN;
                    end else if (!aw_left && !w_left) begin
                        bready_q <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_resp    <= axi.bresp;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end else if (tmo_fire) begin
                        state <= DRAIN;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                    if (tmo_fire) begin
                        state <= DRAIN;
                    end else if (ar_hs) begin
                        state <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_resp    <= axi.rresp;
                        rsp_rdata   <= axi.rdata;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end else if (tmo_fire) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish every channel of the aborted transaction, discarding the response.
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs) wvalid_q <= 1'b0;
                    if (ar_hs) arvalid_q <= 1'b0;
                    if (drain_wr) begin
                        if (b_hs) begin
                            bready_q  <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (!aw_left && !w_left) begin
                            bready_q <= 1'b1;
                        end
                    end else begin
                        if (r_hs) begin
                            rready_q  <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (!ar_left) begin
                            rready_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_req_master.sv
// Scoreboard bench for axil_req_master against a small AXI4-Lite memory slave model.
`timescale 1ns/1ps
module tb_axil_req_master;
    localparam int ADDR_W = 32;
    localparam int TMO    = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axi4_lite_if #(.ADDR_W(ADDR_W)) axi ();

    axil_req_master #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .axi(axi)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cnt = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_age = 0, w_age = 0;
    int aw_dly = 0, w_dly = 0;
    logic r_hold = 1'b0;
    logic got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0, b_fired = 1'b0, r_fired = 1'b0;
    logic [31:0] aw_addr_l = '0, w_data_l = '0, ar_addr_l = '0, mtmp;
    logic [3:0]  w_strb_l = '0;
    logic [31:0] mem [logic [31:0]];
    logic p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [31:0] p_awa, p_wd, p_ara;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Handshake recorder: samples pre-edge values at each rising edge.
    always @(posedge aclk) begin
        if (req_valid && req_ready) acc_cyc = cyc;
        if (aresetn) begin
            if (axi.awvalid && axi.awready) begin
                aw_cnt++; got_aw = 1'b1; aw_addr_l = axi.awaddr; aw_age = 0;
            end
            if (axi.wvalid && axi.wready) begin
                w_cnt++; got_w = 1'b1; w_data_l = axi.wdata; w_strb_l = axi.wstrb; w_age = 0;
            end
            if (axi.bvalid && axi.bready) begin
                b_cnt++; b_fired = 1'b1;
            end
            if (axi.arvalid && axi.arready) begin
                ar_cnt++; got_ar = 1'b1; ar_addr_l = axi.araddr;
            end
            if (axi.rvalid && axi.rready) begin
                r_cnt++; r_fired = 1'b1;
            end
        end
        cyc++;
    end

    // Slave model: drives its outputs only on falling edges.
    always @(negedge aclk) begin
        if (!aresetn) begin
            axi.bvalid = 1'b0; axi.bresp = '0; axi.rvalid = 1'b0; axi.rresp = '0; axi.rdata = '0;
            got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; b_fired = 1'b0; r_fired = 1'b0;
            aw_age = 0; w_age = 0;
        end else begin
            if (b_fired) begin axi.bvalid = 1'b0; b_fired = 1'b0; end
            if (r_fired) begin axi.rvalid = 1'b0; r_fired = 1'b0; end
            if (got_aw && got_w && !axi.bvalid) begin
                mtmp = mem.exists(aw_addr_l) ? mem[aw_addr_l] : '0;
                for (int i = 0; i < 4; i++) begin
                    if (w_strb_l[i]) mtmp[8*i +: 8] = w_data_l[8*i +: 8];
                end
                mem[aw_addr_l] = mtmp;
                axi.bvalid = 1'b1; axi.bresp = 2'b00;
                got_aw = 1'b0; got_w = 1'b0;
            end
            if (got_ar && !axi.rvalid && !r_hold) begin
                axi.rdata  = mem.exists(ar_addr_l) ? mem[ar_addr_l] : '0;
                axi.rresp  = 2'b00;
                axi.rvalid = 1'b1;
                got_ar = 1'b0;
            end
            if (axi.awvalid && !axi.awready) aw_age++;
            if (axi.wvalid && !axi.wready) w_age++;
        end
        axi.awready = (aw_age >= aw_dly);
        axi.wready  = (w_age >= w_dly);
        axi.arready = 1'b1;
    end

    // Monitor: pops the scoreboard on every response and checks held valids.
    always @(negedge aclk) begin
        if (aresetn && rsp_valid) begin
            rsp_cnt++;
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got rsp_valid with resp %0d, required none", rsp_resp);
            end else begin
                mon_e = sbq.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_resp", 32'(rsp_resp), 32'(mon_e.resp));
                check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
                if (mon_e.lat > 0) check("rsp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
            end
        end
        if (aresetn) begin
            if (p_awv && !p_awr) begin
                check("awvalid_held", 32'(axi.awvalid), 32'd1);
                check("awaddr_stable", axi.awaddr, p_awa);
            end
            if (p_wv && !p_wr) begin
                check("wvalid_held", 32'(axi.wvalid), 32'd1);
                check("wdata_stable", axi.wdata, p_wd);
            end
            if (p_arv && !p_arr) begin
                check("arvalid_held", 32'(axi.arvalid), 32'd1);
                check("araddr_stable", axi.araddr, p_ara);
            end
            p_awv = axi.awvalid; p_awr = axi.awready; p_awa = axi.awaddr;
            p_wv  = axi.wvalid;  p_wr  = axi.wready;  p_wd  = axi.wdata;
            p_arv = axi.arvalid; p_arr = axi.arready; p_ara = axi.araddr;
        end else begin
            p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
        end
    end

    // Drives one request, pushes its expectation when acceptance is imminent,
    // and returns in the cycle right after acceptance.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] e_rdata, input logic [1:0] e_resp,
                         input logic e_tmo, input int e_lat, input logic push);
        exp_t e;
        int n;
        @(negedge aclk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL req_accept: req_ready 0 after %0d cycles, required 1", n);
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            e.rdata = e_rdata; e.resp = e_resp; e.tmo = e_tmo; e.lat = e_lat;
            sbq.push_back(e);
        end
        @(negedge aclk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check(name, 32'(rsp_cnt), 32'(target));
    endtask

    int aw0, w0, r0, rc0;

    initial begin
        mem[32'h200] = 32'hFFFF_FFFF;
        repeat (3) @(negedge aclk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'd0);
        check("rst_awaddr", axi.awaddr, 32'd0);
        check("rst_araddr", axi.araddr, 32'd0);
        check("rst_wdata", axi.wdata, 32'd0);
        aresetn = 1'b1;

        // Zero-wait write then readback.
        issue(1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1'b0, 3, 1'b1);
        check("n1_awvalid", 32'(axi.awvalid), 32'd1);
        check("n1_wvalid", 32'(axi.wvalid), 32'd1);
        check("n1_awaddr", axi.awaddr, 32'h104);
        check("n1_wdata", axi.wdata, 32'hDEAD_BEEF);
        wait_rsp("wr_done", 1);
        issue(1'b0, 32'h104, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 3, 1'b1);
        wait_rsp("rd_done", 2);

        // AW delayed 5 cycles, W immediate.
        aw_dly = 5; w_dly = 0; aw0 = aw_cnt; w0 = w_cnt;
        issue(1'b1, 32'h108, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00, 1'b0, 7, 1'b1);
        wait_rsp("skew_aw_done", 3);
        check("skew_aw_awcnt", 32'(aw_cnt - aw0), 32'd1);
        check("skew_aw_wcnt", 32'(w_cnt - w0), 32'd1);
        // W delayed 5 cycles, AW immediate.
        aw_dly = 0; w_dly = 5; aw0 = aw_cnt; w0 = w_cnt;
        issue(1'b1, 32'h10C, 32'h5A5A_0002, 4'hF, 32'h0, 2'b00, 1'b0, 7, 1'b1);
        wait_rsp("skew_w_done", 4);
        check("skew_w_awcnt", 32'(aw_cnt - aw0), 32'd1);
        check("skew_w_wcnt", 32'(w_cnt - w0), 32'd1);
        w_dly = 0;
        issue(1'b0, 32'h108, 32'h0, 4'h0, 32'hA5A5_0001, 2'b00, 1'b0, 3, 1'b1);
        wait_rsp("rb108_done", 5);
        issue(1'b0, 32'h10C, 32'h0, 4'h0, 32'h5A5A_0002, 2'b00, 1'b0, 3, 1'b1);
        wait_rsp("rb10c_done", 6);

        // Partial strobe over an all-ones word.
        issue(1'b1, 32'h200, 32'h1122_3344, 4'h3, 32'h0, 2'b00, 1'b0, 3, 1'b1);
        wait_rsp("strb_wr_done", 7);
        issue(1'b0, 32'h200, 32'h0, 4'h0, 32'hFFFF_3344, 2'b00, 1'b0, 3, 1'b1);
        wait_rsp("strb_rd_done", 8);

        // Unaligned read is issued word-aligned.
        issue(1'b0, 32'h107, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 3, 1'b1);
        check("unaligned_araddr_bus", axi.araddr, 32'h104);
        wait_rsp("unaligned_done", 9);
        check("unaligned_araddr", ar_addr_l, 32'h104);

        // Slave withholds rvalid: watchdog response, then silent drain.
        r_hold = 1'b1;
        issue(1'b0, 32'h104, 32'h0, 4'h0, 32'h0, 2'b11, 1'b1, 16, 1'b1);
        wait_rsp("tmo_done", 10);
        check("tmo_req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge aclk);
        check("tmo_req_ready_drain", 32'(req_ready), 32'd0);
        r0 = r_cnt; rc0 = rsp_cnt;
        r_hold = 1'b0;
        for (int n = 0; n < 50 && r_cnt == r0; n++) @(negedge aclk);
        check("drain_r_hs", 32'(r_cnt - r0), 32'd1);
        check("drain_req_ready", 32'(req_ready), 32'd1);
        repeat (5) @(negedge aclk);
        check("drain_no_rsp", 32'(rsp_cnt), 32'(rc0));

        // Reset while waiting in WRESP with bvalid arriving.
        issue(1'b1, 32'h300, 32'h0BAD_F00D, 4'hF, 32'h0, 2'b00, 1'b0, 0, 1'b0);
        @(negedge aclk);
        #1;
        check("pre_rst_bready", 32'(axi.bready), 32'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_bready", 32'(axi.bready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_valids", {28'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        rc0 = rsp_cnt;
        issue(1'b0, 32'h104, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 3, 1'b1);
        wait_rsp("post_rst_rd_done", rc0 + 1);

        repeat (4) @(negedge aclk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "bench stalled");
    end
endmodule
